hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MD_LATENCY, default 4, range 2..16: number of cycles the multi-cycle mul/div op holds the Execute stage before its completion cycle.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  pipeline clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 Rs1_D, Rs2_D  in  5 each  source registers of the instruction in Decode.
REQ-006 RD_E  in  5  destination register of the instruction in Execute.
REQ-007 RegWriteE, MemReadE  in  1 each  Execute instruction writes the register file / is a load.
REQ-008 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-009 MulDivStartE  in  1  Execute holds a mul/div op; stays high for every cycle that op is in Execute.
REQ-010 StallCntClr  in  1  synchronous clear of the stall counter.
REQ-011 StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-012 FlushD, FlushE  out  1 each  bubble the IF/ID and ID/EX registers.
REQ-013 MulDivDoneE  out  1  mul/div result is valid in Execute this cycle.
REQ-014 StallCycles  out  16  performance count of cycles with StallF=1.

Function
REQ-015 lwStall SHALL be MemReadE & RegWriteE & (RD_E!=0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D)), combinational.
REQ-016 FSM states IDLE, BUSY, DONE; 5-bit down-counter cnt.
REQ-017 IDLE & MulDivStartE: cnt<=MD_LATENCY-2, next BUSY. IDLE otherwise: stay IDLE.
REQ-018 BUSY: cnt==0 -> DONE, else cnt<=cnt-1; MulDivStartE ignored.
REQ-019 DONE -> IDLE unconditionally; MulDivStartE high in DONE SHALL NOT restart (same instruction).
REQ-020 mdHold = (IDLE & MulDivStartE) | BUSY, combinational.
REQ-021 StallE = mdHold.
REQ-022 StallF = StallD = lwStall | mdHold.
REQ-023 FlushD = PCSrcE & ~mdHold.
REQ-024 FlushE = (lwStall | PCSrcE) & ~mdHold.
REQ-025 MulDivDoneE = 1 only in DONE.
REQ-026 A mul/div op occupies Execute exactly MD_LATENCY+1 cycles: MD_LATENCY stalled cycles, then one DONE cycle.
REQ-027 lwStall and PCSrcE are mutually exclusive by construction (one instruction in Execute).
REQ-028 PCSrcE or MemReadE asserted while mdHold is a protocol violation; stall outputs keep priority.
REQ-029 StallCycles increments by 1 on each rising edge with StallF=1, saturating at 0xFFFF.
REQ-030 StallCntClr=1 sets StallCycles to 0 on that edge; clear wins over increment.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, cnt=0, StallCycles=0, independent of clk.
REQ-032 During reset, combinational outputs follow REQ-015..025 with state IDLE, so MulDivDoneE=0.
REQ-033 Reset mid-op abandons the operation; the first post-reset cycle behaves as IDLE.

Structure
REQ-034 State encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and MD_LATENCY bounds SHALL live in shared package hazard_pkg.
REQ-035 The FSM and counter SHALL be one sub-module md_busy_fsm, with outputs mdHold and MulDivDoneE.
REQ-036 The load-use compare and flush logic SHALL be combinational in the top module.

Verification
REQ-037 Load-use: MemReadE=1, RegWriteE=1, RD_E=5, Rs2_D=5 -> StallF=StallD=FlushE=1, StallE=0, FlushD=0 for one cycle.
REQ-038 x0 case: same stimulus as REQ-037 with RD_E=0 -> all stall and flush outputs 0; StallCycles unchanged.
REQ-039 Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, all stalls 0.
REQ-040 Mul/div, MD_LATENCY=4: MulDivStartE held 5 cycles -> StallF/D/E=1 on cycles 0-3, MulDivDoneE=1 only on cycle 4, StallCycles +4.
REQ-041 Reset at cycle 2 of a mul/div op -> outputs drop asynchronously, state IDLE, StallCycles=0. Holding MulDivStartE after release restarts a fresh 4+1 sequence.
REQ-042 Saturation: preload 0xFFFE and stall 3 cycles -> StallCycles=0xFFFF. StallCntClr concurrent with a stall -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings, latency bounds and counter helpers
// for the hazard/stall unit.
package hazard_pkg;

    localparam int MD_LATENCY_MIN = 2;
    localparam int MD_LATENCY_MAX = 16;
    localparam int CNT_W          = 5;
    localparam int PERF_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Value loaded on op start so that BUSY spans MD_LATENCY-1 cycles.
    function automatic logic [CNT_W-1:0] md_start_count(input int latency);
        return CNT_W'(latency - 2);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_fsm.sv
// md_busy_fsm: tracks a multi-cycle mul/div op in Execute and produces the
// hold and completion strobes.
module md_busy_fsm
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic MulDivStartE,
    output logic mdHold,
    output logic MulDivDoneE
);

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // DONE always returns to IDLE so a start still high there is not a restart.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (MulDivStartE) begin
                    state_n = BUSY;
                    cnt_n   = md_start_count(MD_LATENCY);
                end
            end
            BUSY: begin
                if (cnt == '0) state_n = DONE;
                else cnt_n = cnt - 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign mdHold      = (state == IDLE && MulDivStartE) || state == BUSY;
    assign MulDivDoneE = state == DONE;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and mul/div stall generation, branch flushes
// and a saturating stall-cycle performance counter.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs1_D,
    input  logic [4:0]        Rs2_D,
    input  logic [4:0]        RD_E,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic              MulDivStartE,
    input  logic              StallCntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MulDivDoneE,
    output logic [PERF_W-1:0] StallCycles
);

    logic lw_stall;
    logic md_hold;

    md_busy_fsm #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk          (clk),
        .rst          (rst),
        .MulDivStartE (MulDivStartE),
        .mdHold       (md_hold),
        .MulDivDoneE  (MulDivDoneE)
    );

    assign lw_stall = MemReadE && RegWriteE && RD_E != 5'd0 &&
                      (RD_E == Rs1_D || RD_E == Rs2_D);

    // Mul/div hold dominates: a flush must not destroy the held instructions.
    assign StallE = md_hold;
    assign StallF = lw_stall || md_hold;
    assign StallD = StallF;
    assign FlushD = PCSrcE && !md_hold;
    assign FlushE = (lw_stall || PCSrcE) && !md_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) StallCycles <= '0;
        else if (StallCntClr) StallCycles <= '0;
        else if (StallF && !(&StallCycles)) StallCycles <= StallCycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of stalls, flushes, the mul/div
// sequence, asynchronous reset and the saturating stall counter.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1_D, Rs2_D, RD_E;
    logic        RegWriteE, MemReadE, PCSrcE, MulDivStartE, StallCntClr;
    logic        StallF, StallD, StallE, FlushD, FlushE, MulDivDoneE;
    logic [15:0] StallCycles;

    int checks = 0;
    int failures = 0;

    hazard_stall_unit #(.MD_LATENCY(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .RD_E         (RD_E),
        .RegWriteE    (RegWriteE),
        .MemReadE     (MemReadE),
        .PCSrcE       (PCSrcE),
        .MulDivStartE (MulDivStartE),
        .StallCntClr  (StallCntClr),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .MulDivDoneE  (MulDivDoneE),
        .StallCycles  (StallCycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed {StallF,StallD,StallE,FlushD,FlushE,MulDivDoneE}
    function automatic logic [15:0] outs();
        return {10'd0, StallF, StallD, StallE, FlushD, FlushE, MulDivDoneE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1_D = 5'd0; Rs2_D = 5'd0; RD_E = 5'd0;
        RegWriteE = 1'b0; MemReadE = 1'b0; PCSrcE = 1'b0;
        MulDivStartE = 1'b0; StallCntClr = 1'b0;
    endtask

    task automatic mul_div_seq(input string tag, input logic [15:0] base);
        MulDivStartE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("%s_outs_c%0d", tag, i), outs(),
                (i < 4) ? 16'b111000 : 16'b000001);
            tick();
        end
        MulDivStartE = 1'b0;
        #1;
        chk({tag, "_after_outs"}, outs(), 16'b000000);
        chk({tag, "_after_cnt"}, StallCycles, base + 16'd4);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset_cnt", StallCycles, 16'd0);
        chk("reset_outs", outs(), 16'b000000);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_cnt", StallCycles, 16'd0);

        // Load-use hazard on Rs2
        MemReadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; Rs2_D = 5'd5; Rs1_D = 5'd3;
        #1;
        chk("lw_outs", outs(), 16'b110010);
        tick();
        idle_inputs();
        #1;
        chk("lw_cnt", StallCycles, 16'd1);
        chk("lw_clear_outs", outs(), 16'b000000);

        // Load-use on Rs1 too
        MemReadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd9; Rs1_D = 5'd9; Rs2_D = 5'd1;
        #1;
        chk("lw_rs1_outs", outs(), 16'b110010);
        RegWriteE = 1'b0;
        #1;
        chk("lw_no_regwrite_outs", outs(), 16'b000000);
        tick();
        idle_inputs();

        // x0 destination never stalls
        MemReadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd0; Rs2_D = 5'd0;
        #1;
        chk("x0_outs", outs(), 16'b000000);
        tick();
        idle_inputs();
        chk("x0_cnt", StallCycles, 16'd1);

        // Branch taken
        PCSrcE = 1'b1;
        #1;
        chk("br_outs", outs(), 16'b000110);
        tick();
        idle_inputs();
        chk("br_cnt", StallCycles, 16'd1);

        // Mul/div 4+1 sequence
        mul_div_seq("md", 16'd1);

        // Clear concurrent with a stall
        MemReadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; StallCntClr = 1'b1;
        tick();
        idle_inputs();
        chk("clr_cnt", StallCycles, 16'd0);

        // Reset at cycle 2 of a mul/div op
        MulDivStartE = 1'b1;
        tick();
        tick();
        #1;
        chk("md_mid_outs", outs(), 16'b111000);
        MulDivStartE = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", outs(), 16'b000000);
        chk("rst_mid_cnt", StallCycles, 16'd0);
        tick();
        rst = 1'b0;
        mul_div_seq("md_post_rst", 16'd0);

        // Saturation
        StallCntClr = 1'b1;
        tick();
        StallCntClr = 1'b0;
        chk("sat_start_cnt", StallCycles, 16'd0);
        MemReadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd4; Rs1_D = 5'd4;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre_cnt", StallCycles, 16'hFFFE);
        repeat (3) tick();
        chk("sat_cnt", StallCycles, 16'hFFFF);
        StallCntClr = 1'b1;
        tick();
        chk("sat_clr_cnt", StallCycles, 16'd0);
        idle_inputs();
        tick();
        chk("final_cnt", StallCycles, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
